// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the DES key schedule and its round-key consumer.
// parity_err exists only when DES_KEY_PARITY_CHK_EN is defined.
interface des_key_schedule_if;
    logic        key_load;
    logic [63:0] key;
    logic        decrypt;
    logic        flush;
    logic        rk_ready;
    logic        rk_valid;
    logic [47:0] round_key;
    logic [3:0]  rk_idx;
    logic        busy;
    logic        done;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        parity_err;

    modport master (
        output key_load, key, decrypt, flush, rk_ready,
        input  rk_valid, round_key, rk_idx, busy, done, parity_err
    );
    modport slave (
        input  key_load, key, decrypt, flush, rk_ready,
        output rk_valid, round_key, rk_idx, busy, done, parity_err
    );
`else
    modport master (
        output key_load, key, decrypt, flush, rk_ready,
        input  rk_valid, round_key, rk_idx, busy, done
    );
    modport slave (
        input  key_load, key, decrypt, flush, rk_ready,
        output rk_valid, round_key, rk_idx, busy, done
    );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 at load, then one PC-2 subkey per valid/ready transfer.
// Optional key-byte odd-parity check is enabled with DES_KEY_PARITY_CHK_EN.
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input logic                 clk,
    input logic                 rst,
    des_key_schedule_if.slave   bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Table bit n (1 = MSB) of an N-bit vector lives at vector index N-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] res;
        res = '0;
        for (int i = 0; i < 56; i++) res[55 - i] = k[64 - PC1[i]];
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) res[47 - i] = cd[56 - PC2[i]];
        return res;
    endfunction

    function automatic logic [1:0] shiftOf(input int roundNum);
        return (roundNum == 1 || roundNum == 2 || roundNum == 9 || roundNum == 16) ? 2'd1 : 2'd2;
    endfunction

    function automatic int decRot();
        int s;
        s = 0;
        for (int r = 1; r <= ROUNDS; r++) s += int'(shiftOf(r));
        return s % 28;
    endfunction

    function automatic logic [27:0] rotlN(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    localparam int         DEC_ROT  = decRot();
    localparam logic [3:0] IDX_LAST = 4'(ROUNDS - 1);

    logic [0:0]  r_state;
    logic [27:0] r_c, r_d;
    logic [3:0]  r_idx;
    logic        r_done;
    logic        r_decrypt;

    logic [55:0] w_cd0;
    logic [27:0] w_c0, w_d0;
    logic [1:0]  w_shAmt;
    logic [27:0] w_cStep, w_dStep;
    logic        w_xfer, w_last;

    assign w_cd0 = pc1(bus.key);
    assign w_c0  = w_cd0[55:28];
    assign w_d0  = w_cd0[27:0];

    assign w_xfer = (r_state == ST_RUN) && bus.rk_ready;
    assign w_last = r_decrypt ? (r_idx == 4'd0) : (r_idx == IDX_LAST);

    // Encrypt steps forward by S[idx+2]; decrypt undoes the shift that produced the current subkey.
    always_comb begin
        w_shAmt = r_decrypt ? shiftOf(int'(r_idx) + 1) : shiftOf(int'(r_idx) + 2);
        w_cStep = r_c;
        w_dStep = r_d;
        if (r_decrypt) begin
            w_cStep = (w_shAmt == 2'd1) ? {r_c[0], r_c[27:1]} : {r_c[1:0], r_c[27:2]};
            w_dStep = (w_shAmt == 2'd1) ? {r_d[0], r_d[27:1]} : {r_d[1:0], r_d[27:2]};
        end else begin
            w_cStep = (w_shAmt == 2'd1) ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
            w_dStep = (w_shAmt == 2'd1) ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_decrypt <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                if (bus.key_load) begin
                    r_state   <= ST_RUN;
                    r_decrypt <= bus.decrypt;
                    if (bus.decrypt) begin
                        r_c   <= rotlN(w_c0, DEC_ROT);
                        r_d   <= rotlN(w_d0, DEC_ROT);
                        r_idx <= IDX_LAST;
                    end else begin
                        r_c   <= {w_c0[26:0], w_c0[27]};
                        r_d   <= {w_d0[26:0], w_d0[27]};
                        r_idx <= 4'd0;
                    end
                end
            end else if (w_xfer) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_c   <= w_cStep;
                    r_d   <= w_dStep;
                    r_idx <= r_decrypt ? (r_idx - 4'd1) : (r_idx + 4'd1);
                end
            end
        end
    end

    assign bus.rk_valid  = (r_state == ST_RUN);
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = r_done;
    assign bus.rk_idx    = r_idx;
    assign bus.round_key = pc2({r_c, r_d});

`ifdef DES_KEY_PARITY_CHK_EN
    logic w_badParity;
    logic r_parityErr;

    // DES key bytes carry odd parity; an even byte flags the key as suspect.
    always_comb begin
        w_badParity = 1'b0;
        for (int b = 0; b < 8; b++) w_badParity = w_badParity | ~(^bus.key[b*8 +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parityErr <= 1'b0;
        end else if (bus.flush) begin
            r_parityErr <= 1'b0;
        end else if (r_state == ST_IDLE && bus.key_load) begin
            r_parityErr <= w_badParity;
        end
    end

    assign bus.parity_err = r_parityErr;
`endif
endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known DES vectors, randomized sessions with
// random back-pressure, flush, async reset and (when enabled) the parity flag.
module tb_des_key_schedule;
    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KNOWN_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KNOWN_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    des_key_schedule_if bus();

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Subkey n straight from the DES definition: C0D0 rotated by the cumulative shift, then PC-2.
    function automatic logic [47:0] refSubkey(input logic [63:0] key, input int n);
        logic        kb [1:64];
        logic        c0 [0:27];
        logic        d0 [0:27];
        logic        cd [1:56];
        logic [47:0] k;
        int          tot;
        for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
        tot = 0;
        for (int r = 1; r <= n; r++) tot += SH_T[r - 1];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1_T[i]];
            d0[i] = kb[PC1_T[28 + i]];
        end
        for (int i = 0; i < 28; i++) begin
            cd[i + 1]  = c0[(i + tot) % 28];
            cd[29 + i] = d0[(i + tot) % 28];
        end
        k = '0;
        for (int j = 0; j < 48; j++) k[47 - j] = cd[PC2_T[j]];
        return k;
    endfunction

    function automatic logic refParityBad(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++)
            if ($countones(key[b*8 +: 8]) % 2 == 0) bad = 1'b1;
        return bad;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [2:0] expFlags);
        checkOutput(tag, {61'd0, bus.rk_valid, bus.busy, bus.done}, {61'd0, expFlags});
    endtask

    // One full load-to-done session with random readiness and junk on the ignored inputs.
    task automatic applyStimulus(input logic [63:0] key, input logic dec, input int readyPct);
        int   expIdx;
        int   lastIdx;
        int   cycles;
        bit   finished;
        logic rdy;
        bus.key      = key;
        bus.decrypt  = dec;
        bus.key_load = 1'b1;
        bus.rk_ready = 1'b0;
        tick();
        bus.key_load = 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
        checkOutput("parityErr", {63'd0, bus.parity_err}, {63'd0, refParityBad(key)});
`endif
        expIdx   = dec ? 15 : 0;
        lastIdx  = dec ? 0 : 15;
        cycles   = 0;
        finished = 1'b0;
        while (!finished && cycles < 400) begin
            checkFlags("runFlags", 3'b110);
            checkOutput("rkIdx", {60'd0, bus.rk_idx}, 64'(expIdx));
            checkOutput("roundKey", {16'd0, bus.round_key}, {16'd0, refSubkey(key, expIdx + 1)});
            rdy          = ($urandom_range(99) < readyPct);
            bus.rk_ready = rdy;
            bus.decrypt  = 1'($urandom);
            bus.key_load = ($urandom_range(3) == 0);
            bus.key      = {$urandom, $urandom};
            tick();
            cycles++;
            if (rdy) begin
                if (expIdx == lastIdx) finished = 1'b1;
                else expIdx = dec ? expIdx - 1 : expIdx + 1;
            end
        end
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b0;
        if (!finished) checkOutput("sessionTimeout", 64'd0, 64'd1);
        checkFlags("doneFlags", 3'b001);
        tick();
        checkFlags("idleFlags", 3'b000);
    endtask

    task automatic knownVector(input logic dec);
        bus.key      = KNOWN_KEY;
        bus.decrypt  = dec;
        bus.key_load = 1'b1;
        bus.rk_ready = 1'b1;
        tick();
        bus.key_load = 1'b0;
        checkOutput("knownFirstIdx", {60'd0, bus.rk_idx}, dec ? 64'd15 : 64'd0);
        checkOutput("knownFirstKey", {16'd0, bus.round_key}, {16'd0, dec ? KNOWN_K16 : KNOWN_K1});
        for (int i = 0; i < 15; i++) tick();
        checkFlags("knownLastFlags", 3'b110);
        checkOutput("knownLastIdx", {60'd0, bus.rk_idx}, dec ? 64'd0 : 64'd15);
        checkOutput("knownLastKey", {16'd0, bus.round_key}, {16'd0, dec ? KNOWN_K1 : KNOWN_K16});
        tick();
        checkFlags("knownDone", 3'b001);
        bus.rk_ready = 1'b0;
        tick();
        checkFlags("knownIdle", 3'b000);
    endtask

    initial begin
        logic [63:0] keyA;
        logic [63:0] keyB;
        tests        = 0;
        failures     = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        bus.key_load = 1'b0;
        bus.key      = '0;
        bus.decrypt  = 1'b0;
        bus.flush    = 1'b0;
        bus.rk_ready = 1'b0;
        #12;
        checkFlags("resetFlags", 3'b000);
        checkOutput("resetIdx", {60'd0, bus.rk_idx}, 64'd0);
        checkOutput("resetKey", {16'd0, bus.round_key}, 64'd0);
`ifdef DES_KEY_PARITY_CHK_EN
        checkOutput("resetParity", {63'd0, bus.parity_err}, 64'd0);
`endif
        #4 rst = 1'b0;
        tick();
        checkFlags("idleNoLoad", 3'b000);

        knownVector(1'b0);
        knownVector(1'b1);
        applyStimulus(KNOWN_KEY, 1'b0, 50);
        for (int s = 0; s < 6; s++) applyStimulus({$urandom, $urandom}, 1'($urandom), (s % 2) ? 100 : 45);

        // key_load during RUN is ignored; flush at K9 aborts without done.
        keyA = {$urandom, $urandom};
        keyB = ~keyA;
        bus.key = keyA; bus.decrypt = 1'b0; bus.key_load = 1'b1; bus.rk_ready = 1'b1;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("flushK5Idx", {60'd0, bus.rk_idx}, 64'd4);
        bus.key = keyB; bus.decrypt = 1'b1; bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        checkOutput("ignoredLoadIdx", {60'd0, bus.rk_idx}, 64'd5);
        checkOutput("ignoredLoadKey", {16'd0, bus.round_key}, {16'd0, refSubkey(keyA, 6)});
        for (int i = 0; i < 3; i++) tick();
        checkOutput("flushK9Key", {16'd0, bus.round_key}, {16'd0, refSubkey(keyA, 9)});
        bus.flush = 1'b1; bus.key_load = 1'b1;
        tick();
        bus.flush = 1'b0; bus.key_load = 1'b0; bus.rk_ready = 1'b0;
        checkFlags("flushFlags", 3'b000);
        tick();
        checkFlags("flushNoDone", 3'b000);

        // Asynchronous reset in the middle of a cycle while K7 is presented.
        bus.key = keyA; bus.decrypt = 1'b0; bus.key_load = 1'b1; bus.rk_ready = 1'b1;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rstK7Idx", {60'd0, bus.rk_idx}, 64'd6);
        #2 rst = 1'b1;
        #1;
        checkFlags("asyncRstFlags", 3'b000);
        checkOutput("asyncRstKey", {16'd0, bus.round_key}, 64'd0);
        bus.rk_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        knownVector(1'b0);

`ifdef DES_KEY_PARITY_CHK_EN
        applyStimulus(KNOWN_KEY, 1'b0, 60);
        applyStimulus(64'h133457799BBCDFF0, 1'b0, 60);
        bus.key = 64'h133457799BBCDFF0; bus.key_load = 1'b1; bus.decrypt = 1'b0;
        tick();
        bus.key_load = 1'b0;
        checkOutput("parityBadKey", {63'd0, bus.parity_err}, 64'd1);
        checkOutput("parityBadK1", {16'd0, bus.round_key}, {16'd0, KNOWN_K1});
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("parityFlushClr", {63'd0, bus.parity_err}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end
endmodule
